// File: rtl/hal2.sv
// HAL2: a tiny accumulator machine with a unified word memory.
// Each instruction takes two cycles: FETCH latches the low 16 bits of mem[pc]
// into ir, and EXEC performs the operation and retires it.
// A program is loaded through the prog_* port while the machine is halted.
// Eight constant registers r[i]=i supply operands for ADR.
module hal2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] prog_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_JRP = 3'b001;
  localparam logic [2:0] OP_LDA = 3'b010;
  localparam logic [2:0] OP_STO = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SKN = 3'b101;
  localparam logic [2:0] OP_ADR = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Architectural state
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state_r;
  logic [15:0]       ir_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              halted_r;
  logic [DATA_W-1:0] regs_r [8];

  // Decoded instruction fields
  logic [2:0]        op_s;
  logic [ADDR_W-1:0] a_s;
  logic [2:0]        ra_s;
  logic [2:0]        rb_s;

  // The core's single read port: pc during FETCH, operand address otherwise
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_data_s;

  // Results of the instruction currently in EXEC
  logic [ADDR_W-1:0] pc_next_s;
  logic [DATA_W-1:0] acc_next_s;

  // Memory write port (program loader in HALT or STO in EXEC)
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Operand-address bits above ADDR_W are deliberately ignored
  logic unused_ir_s;

  assign op_s        = ir_r[15:13];
  assign a_s         = ir_r[ADDR_W-1:0];
  assign ra_s        = ir_r[12:10];
  assign rb_s        = ir_r[2:0];
  assign unused_ir_s = ^ir_r;

  assign rd_addr_s = (state_r == ST_EXEC) ? a_s : pc_r;
  assign rd_data_s = mem[rd_addr_s];

  assign prog_rdata  = mem[prog_addr];
  assign pc          = pc_r;
  assign acc         = acc_r;
  assign halted      = halted_r;
  assign instr_count = cnt_r;

  // Compute the single pc update and accumulator result of the EXEC opcode
  always_comb begin
    pc_next_s  = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    acc_next_s = acc_r;
    case (op_s)
      OP_JMP: begin
        pc_next_s = a_s;
      end
      OP_JRP: begin
        pc_next_s = pc_r + a_s;
      end
      OP_LDA: begin
        acc_next_s = rd_data_s;
      end
      OP_STO: begin
        acc_next_s = acc_r;
      end
      OP_SUB: begin
        acc_next_s = acc_r - rd_data_s;
      end
      OP_SKN: begin
        if (acc_r[DATA_W-1]) begin
          pc_next_s = pc_r + {{(ADDR_W-2){1'b0}}, 2'd2};
        end else begin
          pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      OP_ADR: begin
        acc_next_s = regs_r[ra_s] + regs_r[rb_s];
      end
      OP_HLT: begin
        pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      default: begin
        pc_next_s  = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        acc_next_s = acc_r;
      end
    endcase
  end

  // Select the memory writer; the loader and STO never overlap because of state
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = prog_addr;
    mem_wdata_s = prog_data;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if ((state_r == ST_HALT) && prog_we) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = prog_addr;
      mem_wdata_s = prog_data;
    end else if ((state_r == ST_EXEC) && (op_s == OP_STO)) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = a_s;
      mem_wdata_s = acc_r;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Unified memory: contents survive reset, one write per cycle
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Control FSM with registered pc, acc, ir, counter and halted flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_HALT;
      halted_r <= 1'b1;
      pc_r     <= '0;
      acc_r    <= '0;
      ir_r     <= 16'h0000;
      cnt_r    <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= DATA_W'(i);
      end
    end else begin
      case (state_r)
        ST_HALT: begin
          if (run) begin
            state_r  <= ST_FETCH;
            halted_r <= 1'b0;
          end else begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir_r     <= rd_data_s[15:0];
          state_r  <= ST_EXEC;
          halted_r <= 1'b0;
        end
        ST_EXEC: begin
          pc_r  <= pc_next_s;
          acc_r <= acc_next_s;
          cnt_r <= sat_inc(cnt_r);
          if (op_s == OP_HLT) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_FETCH;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/hal2.md
HAL2 -- requirements
Module: hal2

Interface
REQ-001 SHALL expose parameter DATA_W, default 32; accumulator, register and memory word width; legal range 16..64.
REQ-002 SHALL expose parameter ADDR_W, default 5; unified memory depth is 2**ADDR_W words; legal range 3..13.
REQ-003 SHALL expose parameter CNT_W, default 16; width of the retired-instruction counter.
REQ-004 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port run, input, 1 bit; start execution from HALT.
REQ-007 SHALL have ports prog_we (input, 1), prog_addr (input, ADDR_W) and prog_data (input, DATA_W); memory load port.
REQ-008 SHALL have port prog_rdata, output, DATA_W; combinational mem[prog_addr].
REQ-009 SHALL have ports pc (output, ADDR_W), acc (output, DATA_W), halted (output, 1) and instr_count (output, CNT_W).

Function
REQ-010 SHALL use a 3-state FSM: HALT, FETCH and EXEC; halted=1 exactly in HALT.
REQ-011 In HALT, SHALL go to FETCH on run=1; pc, acc and registers SHALL hold.
REQ-012 In FETCH, SHALL load ir with mem[pc][15:0] and go to EXEC; each instruction takes exactly 2 cycles.
REQ-013 Instruction format: opcode = ir[15:13]; operand address a = ir[ADDR_W-1:0]; upper operand bits are ignored.
REQ-014 In EXEC, SHALL perform the opcode below and return to FETCH, except on HLT.
REQ-015 Unless stated otherwise, pc SHALL become pc+1 modulo 2**ADDR_W in EXEC.
REQ-016 000 JMP: pc <= a.
REQ-017 001 JRP: pc <= pc + ir[ADDR_W-1:0], modulo 2**ADDR_W; this is a wrapping relative jump.
REQ-018 010 LDA: acc <= mem[a].
REQ-019 011 STO: mem[a] <= acc.
REQ-020 100 SUB: acc <= acc - mem[a], two's complement wrap, no flags.
REQ-021 101 SKN: if acc[DATA_W-1]=1, pc <= pc+2 (mod depth); otherwise pc+1.
REQ-022 110 ADR: acc <= r[ir[12:10]] + r[ir[2:0]], truncated to DATA_W.
REQ-023 111 HLT: pc <= pc+1 and go to HALT; a later run resumes at the next instruction.
REQ-024 SHALL provide eight DATA_W registers r[0..7], read-only to the program.
REQ-025 Exactly one pc assignment SHALL take effect per EXEC; there SHALL be no default increment overriding a jump.
REQ-026 instr_count SHALL increment once per EXEC cycle, including HLT, and SHALL saturate at all-ones.
REQ-027 prog_we SHALL write mem[prog_addr] <= prog_data only in HALT; it SHALL be ignored in FETCH and EXEC.
REQ-028 run SHALL be ignored outside HALT.
REQ-029 Memory SHALL be a single read port plus one write per cycle; there is no write conflict, because STO and prog_we are mutually exclusive by state.

Reset
REQ-030 On reset=1 at a clock edge, the FSM SHALL go to HALT, pc=0, acc=0, ir=0, instr_count=0 and r[i]=i for i=0..7.
REQ-031 Reset SHALL override run, prog_we and any in-flight instruction, including a STO in EXEC, which SHALL NOT write.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification (DATA_W=32, ADDR_W=5)
REQ-033 Reset check: assert reset for 1 cycle -> halted=1, pc=0, acc=0, instr_count=0.
REQ-034 Program check: load mem[0..3] = h400A, h800B, h600C, hE000 and mem[10]=7, mem[11]=9, then pulse run -> 8 cycles later halted=1, acc=hFFFFFFFE, prog_rdata at address 12 = hFFFFFFFE, pc=4, instr_count=4.
REQ-035 SKN check: with acc negative from REQ-034, load mem[4]=hA000, mem[5]=hE000, mem[6]=hE000 and run -> halts with pc=7 (mem[5] skipped), instr_count=6.
REQ-036 JRP wrap check: mem[30]=h201F, pc=30 -> after EXEC pc=29 ((30+31) mod 32).
REQ-037 ADR check: mem[0]=hCC05 (r[3]+r[5]) -> acc=8; mem[0]=hDC07 (r[7]+r[7]) -> acc=14.
REQ-038 Mid-operation reset check: assert reset during EXEC of a STO to address 12 -> mem[12] unchanged, halted=1 next cycle; prog_we pulsed while running -> memory unchanged.
